// File: rtl/fir_pkg.sv
// fir_pkg: shared state encoding and default sizing for the FIR stream sequencer.
package fir_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, FLUSH, RUN, DRAIN} state_e;
  localparam int TAPS_DEF    = 25;
  localparam int CNT_W_DEF   = 5;
  localparam int FIR_LAT_DEF = 3;
  localparam int DW          = 8;
endpackage

// File: rtl/fir_valid_pipe.sv
// fir_valid_pipe: LAT-deep valid shift register with synchronous clear.
module fir_valid_pipe #(
  parameter int LAT = 3
) (
  input  logic           clk,
  input  logic           clr_i,
  input  logic           d_i,
  output logic [LAT-1:0] q_o
);
  logic [LAT-1:0] vpipe_q;
  logic [LAT:0]   vpipe_d;
  assign vpipe_d = {vpipe_q, d_i};
  always_ff @(posedge clk) begin
    if (clr_i) vpipe_q <= '0;
    else       vpipe_q <= vpipe_d[LAT-1:0];
  end
  assign q_o = vpipe_q;
endmodule

// File: rtl/fir_stream_ctrl.sv
// fir_stream_ctrl: loads fir_filter coefficients, flushes its delay line, then streams tagged samples.
module fir_stream_ctrl
  import fir_pkg::*;
#(
  parameter int TAPS    = TAPS_DEF,
  parameter int CNT_W   = CNT_W_DEF,
  parameter int FIR_LAT = FIR_LAT_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cfg_start,
  input  logic          cfg_valid,
  input  logic [DW-1:0] cfg_data,
  output logic          cfg_ready,
  input  logic          s_valid,
  input  logic [DW-1:0] s_data,
  output logic          s_ready,
  output logic          m_valid,
  output logic [DW-1:0] m_data,
  output logic          busy,
  output logic          fir_rst,
  output logic          fir_load_c,
  output logic [DW-1:0] fir_coef,
  output logic [DW-1:0] fir_din,
  input  logic [DW-1:0] fir_dout
);
  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [FIR_LAT-1:0] vpipe;
  logic               vclr;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: if (cfg_start) begin
        state_d = LOAD;
        cnt_d   = '0;
      end
      LOAD: if (fir_load_c) begin
        cnt_d   = (cnt_q == CNT_W'(TAPS - 1)) ? '0 : cnt_q + 1'b1;
        state_d = (cnt_q == CNT_W'(TAPS - 1)) ? FLUSH : LOAD;
      end
      FLUSH: begin
        cnt_d   = (cnt_q == CNT_W'(TAPS - 1)) ? '0 : cnt_q + 1'b1;
        state_d = (cnt_q == CNT_W'(TAPS - 1)) ? RUN : FLUSH;
      end
      RUN: if (cfg_start) begin
        state_d = DRAIN;
        cnt_d   = '0;
      end
      DRAIN: begin
        cnt_d   = (cnt_q == CNT_W'(FIR_LAT - 1)) ? '0 : cnt_q + 1'b1;
        state_d = (cnt_q == CNT_W'(FIR_LAT - 1)) ? LOAD : DRAIN;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
  // Gating with reset makes every output take its reset value in the very cycle reset is low.
  assign fir_rst    = !reset;
  assign cfg_ready  = reset && (state_q == LOAD);
  assign s_ready    = reset && (state_q == RUN);
  assign busy       = !s_ready;
  assign fir_load_c = cfg_ready && cfg_valid;
  assign fir_coef   = fir_load_c ? cfg_data : '0;
  assign fir_din    = (s_ready && s_valid) ? s_data : '0;
  assign vclr       = !reset || !(state_q == RUN || state_q == DRAIN);
  fir_valid_pipe #(.LAT(FIR_LAT)) u_vpipe (
    .clk   (clk),
    .clr_i (vclr),
    .d_i   (s_ready && s_valid),
    .q_o   (vpipe)
  );
  assign m_valid = reset && vpipe[FIR_LAT-1];
  assign m_data  = fir_dout;
endmodule

// File: tb/tb_fir_stream_ctrl.sv
// tb_fir_stream_ctrl: drives the sequencer against a behavioural fir_filter and a tap-sum reference model.
module tb_fir_stream_ctrl;
  localparam int TAPS = 25;
  logic clk = 0, reset;
  logic cfg_start, cfg_valid, cfg_ready, s_valid, s_ready, m_valid, busy;
  logic fir_rst, fir_load_c;
  logic [7:0] cfg_data, s_data, m_data, fir_coef, fir_din, fir_dout;
  int n_chk = 0, n_fail = 0, cyc = 0, load_pulses = 0, wi = 0;
  int ref_coef [TAPS];
  int hist [TAPS];
  int dueq [$];
  int datq [$];
  logic [7:0] last_md;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fir_stream_ctrl dut (
    .clk(clk), .reset(reset), .cfg_start(cfg_start), .cfg_valid(cfg_valid), .cfg_data(cfg_data),
    .cfg_ready(cfg_ready), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .m_valid(m_valid), .m_data(m_data), .busy(busy), .fir_rst(fir_rst), .fir_load_c(fir_load_c),
    .fir_coef(fir_coef), .fir_din(fir_din), .fir_dout(fir_dout)
  );

  // Behavioural fir_filter: coefficient chain on load_c, delay line otherwise, 3-cycle in-to-out.
  logic [7:0]  c_q [TAPS];
  logic [7:0]  r_q [TAPS];
  logic [7:0]  p1_q, p2_q;
  logic [17:0] acc;
  always_comb begin
    acc = '0;
    for (int k = 0; k < TAPS; k++) acc = acc + 18'(16'(c_q[k]) * 16'(r_q[k]));
  end
  always @(posedge clk) begin
    if (fir_rst) begin
      for (int k = 0; k < TAPS; k++) begin
        c_q[k] <= '0;
        r_q[k] <= '0;
      end
      p1_q <= '0;
      p2_q <= '0;
    end else begin
      if (fir_load_c) begin
        c_q[0] <= fir_coef;
        for (int k = 1; k < TAPS; k++) c_q[k] <= c_q[k-1];
      end else begin
        r_q[0] <= fir_din;
        for (int k = 1; k < TAPS; k++) r_q[k] <= r_q[k-1];
      end
      p1_q <= acc[15:8];
      p2_q <= p1_q;
    end
  end
  assign fir_dout = p2_q;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int ref_out();
    int s = 0;
    for (int k = 0; k < TAPS; k++) s += ref_coef[k] * hist[k];
    return (s >> 8) & 255;
  endfunction

  // Reference: word i of a load lands on tap TAPS-1-i; each accepted sample yields
  // the tap-weighted sum of the streamed history three cycles later.
  always @(negedge clk) begin
    if (!reset) begin
      wi = 0;
      for (int k = 0; k < TAPS; k++) begin
        ref_coef[k] = 0;
        hist[k] = 0;
      end
      dueq.delete();
      datq.delete();
    end else begin
      if (dueq.size() > 0 && dueq[0] == cyc) begin
        chk("m_valid", 32'(m_valid), 32'd1);
        chk("m_data", 32'(m_data), 32'(datq[0]));
        last_md = m_data;
        void'(dueq.pop_front());
        void'(datq.pop_front());
      end else chk("m_valid", 32'(m_valid), 32'd0);
      if (fir_load_c) load_pulses++;
      if (cfg_valid && cfg_ready) begin
        ref_coef[TAPS-1-wi] = int'(cfg_data);
        if (wi == TAPS - 1) begin
          wi = 0;
          for (int k = 0; k < TAPS; k++) hist[k] = 0;
        end else wi++;
      end
      if (s_ready) begin
        for (int k = TAPS - 1; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = s_valid ? int'(s_data) : 0;
        if (s_valid) begin
          dueq.push_back(cyc + 3);
          datq.push_back(ref_out());
        end
      end
    end
  end

  task automatic drive(input logic v, input logic [7:0] d);
    s_valid = v;
    s_data  = d;
    @(posedge clk); #1;
  endtask

  task automatic stream(input int n);
    for (int i = 0; i < n; i++) drive($urandom_range(0, 3) != 0, 8'($urandom));
  endtask

  task automatic do_load(input bit from_run, input bit gap, input int mode, input int nw);
    int n, p0;
    bit bad;
    cfg_start = 1;
    if (from_run) begin
      s_valid = 1;
      s_data  = 8'($urandom);
    end
    @(posedge clk); #1;
    cfg_start = 0;
    s_valid   = 0;
    n = 0;
    while (n < 100) begin
      @(negedge clk);
      if (n == 0) chk("s_ready_drop", 32'(s_ready), 32'd0);
      if (cfg_ready) break;
      n++;
    end
    chk("load_wait", n, from_run ? 32'd3 : 32'd0);
    @(posedge clk); #1;
    p0 = load_pulses;
    for (int i = 0; i < nw; i++) begin
      cfg_valid = 1;
      cfg_data  = (mode == 0) ? ((i == TAPS - 1) ? 8'hFF : 8'h00) : (mode == 1) ? 8'h01 : 8'($urandom);
      @(posedge clk); #1;
      if (gap && i < nw - 1) begin
        cfg_valid = 0;
        cfg_data  = 8'($urandom);
        @(posedge clk); #1;
      end
    end
    cfg_valid = 0;
    chk("load_pulses", load_pulses - p0, nw);
    if (nw == TAPS) begin
      n = 0;
      bad = 0;
      while (n < 100) begin
        @(negedge clk);
        if (s_ready) break;
        bad |= fir_load_c | (fir_din != 0);
        n++;
      end
      chk("flush_len", n, TAPS);
      chk("flush_zero", 32'(bad), 32'd0);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    reset = 0; cfg_start = 0; cfg_valid = 0; cfg_data = 8'hA5; s_valid = 1; s_data = 8'h5A;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_cfg_ready", 32'(cfg_ready), 0);
    chk("rst_s_ready", 32'(s_ready), 0);
    chk("rst_m_valid", 32'(m_valid), 0);
    chk("rst_busy", 32'(busy), 1);
    chk("rst_load_c", 32'(fir_load_c), 0);
    chk("rst_coef", 32'(fir_coef), 0);
    chk("rst_din", 32'(fir_din), 0);
    chk("rst_fir_rst", 32'(fir_rst), 1);
    @(posedge clk); #1;
    reset = 1; s_valid = 0;
    @(negedge clk);
    chk("rel_fir_rst", 32'(fir_rst), 0);
    chk("rel_busy", 32'(busy), 1);
    chk("idle_cfg_ready", 32'(cfg_ready), 0);
    @(posedge clk); #1;
    do_load(0, 1, 0, TAPS);
    drive(1, 8'h80);
    repeat (6) drive(1, 8'h00);
    chk("impulse", 32'(last_md), 32'h00);
    stream(60);
    do_load(1, 0, 1, TAPS);
    repeat (25) drive(1, 8'h80);
    repeat (6) drive(0, 8'h00);
    chk("settle", 32'(last_md), 32'h0C);
    do_load(1, 1, 2, 10);
    reset = 0;
    @(negedge clk);
    chk("mid_fir_rst", 32'(fir_rst), 1);
    chk("mid_cfg_ready", 32'(cfg_ready), 0);
    @(posedge clk); #1;
    reset = 1;
    @(negedge clk);
    chk("mid_idle", 32'(cfg_ready), 0);
    chk("mid_busy", 32'(busy), 1);
    @(posedge clk); #1;
    do_load(0, 1, 2, TAPS);
    stream(60);
    repeat (6) drive(0, 8'h00);
    chk("pending", dueq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_chk, n_fail);
    $finish;
  end
endmodule
